// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer slice.
//   - Default geometry of the operand banks and the downstream MAC.
//   - Sequencer state encoding, shared by the RTL and anything that
//     needs to decode the state.
package mac_pkg;

  localparam int MAC_VEC_LEN   = 128;
  localparam int MAC_IN_WIDTH  = 16;
  // 2*IN_WIDTH + log2(VEC_LEN): a full-length job of all-ones cannot overflow.
  localparam int MAC_ACC_WIDTH = 39;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_HOLD
  } mac_seq_state_t;

endpackage

// File: rtl/mac_seq_if.sv
// Bundle of all non-clock signals of mac_seq.
//   slave  : the sequencer side (mac_seq).
//   master : the environment side (load/start driver, MAC, result consumer).
// Signals:
//   wr_en/wr_addr/wr_a/wr_b : operand bank write port
//   start/len/busy          : job control
//   mac_a/mac_b/mac_acc_rst : operand stream and accumulator clear to the MAC
//   mac_result              : MAC result register output
//   res_valid/res_data/res_ready : result handshake
interface mac_seq_if #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 39,
  parameter int VEC_LEN   = 128,
  parameter int ADDR_W    = $clog2(VEC_LEN)
) ();

  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [IN_WIDTH-1:0]  wr_a;
  logic [IN_WIDTH-1:0]  wr_b;
  logic                 start;
  logic [ADDR_W:0]      len;
  logic                 busy;
  logic [IN_WIDTH-1:0]  mac_a;
  logic [IN_WIDTH-1:0]  mac_b;
  logic                 mac_acc_rst;
  logic [ACC_WIDTH-1:0] mac_result;
  logic                 res_valid;
  logic [ACC_WIDTH-1:0] res_data;
  logic                 res_ready;

  modport slave (
    input  wr_en, wr_addr, wr_a, wr_b, start, len, mac_result, res_ready,
    output busy, mac_a, mac_b, mac_acc_rst, res_valid, res_data
  );

  modport master (
    output wr_en, wr_addr, wr_a, wr_b, start, len, mac_result, res_ready,
    input  busy, mac_a, mac_b, mac_acc_rst, res_valid, res_data
  );

endinterface

// File: rtl/mac_operand_bank.sv
// Paired operand store: VEC_LEN entries of {A, B}.
// Ports:
//   clk, rst          : clock, async active-high reset (read register only)
//   we/waddr/wdata_*  : synchronous write port
//   re/raddr          : read request, data appears after the next edge
//   rdata_a/rdata_b   : registered read data; forced to zero when re is low,
//                       so the register doubles as the MAC operand output
module mac_operand_bank #(
  parameter int IN_WIDTH = 16,
  parameter int VEC_LEN  = 128,
  parameter int ADDR_W   = $clog2(VEC_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [IN_WIDTH-1:0] wdata_a,
  input  logic [IN_WIDTH-1:0] wdata_b,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [IN_WIDTH-1:0] rdata_a,
  output logic [IN_WIDTH-1:0] rdata_b
);

  // Storage is deliberately not reset: contents survive rst.
  logic [2*IN_WIDTH-1:0] mem [VEC_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {wdata_a, wdata_b};
    end
  end

  // Read stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      {rdata_a, rdata_b} <= mem[raddr];
    end else begin
      rdata_a <= '0;
      rdata_b <= '0;
    end
  end

endmodule

// File: rtl/mac_seq.sv
// Sequencer upstream of the MAC: loads operand pairs while idle, streams
// len pairs into the MAC after clearing its accumulator, waits for the MAC
// result register, and offers the result on a valid/ready handshake.
// Ports:
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : mac_seq_if.slave (bank write, job control, MAC side, result side)
module mac_seq
  import mac_pkg::*;
#(
  parameter int IN_WIDTH  = MAC_IN_WIDTH,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH,
  parameter int VEC_LEN   = MAC_VEC_LEN,
  parameter int ADDR_W    = $clog2(VEC_LEN)
) (
  input logic     clk,
  input logic     rst,
  mac_seq_if.slave bus
);

  localparam int              LEN_W     = ADDR_W + 1;
  localparam logic [LEN_W-1:0] VEC_LEN_L = LEN_W'(VEC_LEN);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > VEC_LEN_L) ? VEC_LEN_L : l;
  endfunction

  mac_seq_state_t       state, state_n;
  logic [LEN_W-1:0]     len_q;
  logic [ADDR_W-1:0]    idx;
  logic [LEN_W-1:0]     idx_nxt;
  logic                 last_elem;
  logic                 drain_cnt;
  logic                 acc_rst_q;
  logic                 res_vld_p2;
  logic [ACC_WIDTH-1:0] res_data_p2;
  logic                 bank_we;
  logic                 bank_re;
  logic [ADDR_W-1:0]    bank_raddr;
  logic [IN_WIDTH-1:0]  op_a_p1;
  logic [IN_WIDTH-1:0]  op_b_p1;

  assign idx_nxt   = {1'b0, idx} + LEN_W'(1);
  assign last_elem = (idx_nxt == len_q);
  assign bank_we   = (state == ST_IDLE) && bus.wr_en &&
                     ({1'b0, bus.wr_addr} < VEC_LEN_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus bank read addressing. The read port is registered, so
  // the address for element k is issued in the cycle before k is presented:
  // element 0 from CLEAR, element idx+1 while element idx is on the MAC.
  always_comb begin
    state_n    = state;
    bank_re    = 1'b0;
    bank_raddr = '0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_n = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_n = (len_q != '0) ? ST_STREAM : ST_DRAIN;
        bank_re = (len_q != '0);
      end
      ST_STREAM: begin
        if (last_elem) state_n = ST_DRAIN;
        bank_re    = !last_elem;
        bank_raddr = idx_nxt[ADDR_W-1:0];
      end
      ST_DRAIN: begin
        if (drain_cnt) state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_vld_p2 && bus.res_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      idx       <= '0;
      drain_cnt <= 1'b0;
      acc_rst_q <= 1'b1;
    end else begin
      if ((state == ST_IDLE) && bus.start) len_q <= clamp_len(bus.len);
      if (state == ST_CLEAR)       idx <= '0;
      else if (state == ST_STREAM) idx <= idx + ADDR_W'(1);
      // Two DRAIN cycles cover the MAC's acc->result register.
      drain_cnt <= (state == ST_DRAIN) && !drain_cnt;
      acc_rst_q <= (state_n == ST_IDLE) || (state_n == ST_CLEAR);
    end
  end

  // Operand stage: bank read register drives the MAC directly
  mac_operand_bank #(
    .IN_WIDTH (IN_WIDTH),
    .VEC_LEN  (VEC_LEN),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (bank_we),
    .waddr    (bus.wr_addr),
    .wdata_a  (bus.wr_a),
    .wdata_b  (bus.wr_b),
    .re       (bank_re),
    .raddr    (bank_raddr),
    .rdata_a  (op_a_p1),
    .rdata_b  (op_b_p1)
  );

  // Result stage: capture on the final DRAIN edge, hold until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld_p2  <= 1'b0;
      res_data_p2 <= '0;
    end else if ((state == ST_DRAIN) && drain_cnt) begin
      res_vld_p2  <= 1'b1;
      res_data_p2 <= bus.mac_result;
    end else if ((state == ST_HOLD) && bus.res_ready) begin
      res_vld_p2  <= 1'b0;
    end
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.mac_a       = op_a_p1;
  assign bus.mac_b       = op_b_p1;
  assign bus.mac_acc_rst = acc_rst_q;
  assign bus.res_valid   = res_vld_p2;
  assign bus.res_data    = res_data_p2;

endmodule
